// File: rtl/sfft_bitstream_decoder.sv
// Decodes stochastic FFT real/imag output bitstreams into per-lane ones-counts over a
// 2**BITWIDTH sample window, after skipping the butterfly pipeline fill.
module sfft_bitstream_decoder #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned NUMINPUTS = 8,
  parameter int unsigned DISCARD   = 3
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iClr,
  input  logic                              iEn,
  input  logic                              iStart,
  input  logic [NUMINPUTS-1:0]              iReal,
  input  logic [NUMINPUTS-1:0]              iImg,
  input  logic                              iAck,
  output logic [NUMINPUTS*(BITWIDTH+1)-1:0] oReal,
  output logic [NUMINPUTS*(BITWIDTH+1)-1:0] oImg,
  output logic                              oValid,
  output logic                              oBusy,
  output logic                              oOvr
);

  localparam int unsigned CW = BITWIDTH + 1;
  localparam int unsigned OW = NUMINPUTS * CW;
  localparam int unsigned DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam logic [DW-1:0] DiscLast = DW'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [BITWIDTH-1:0] SampLast = '1;

  typedef enum logic [1:0] {StIdle, StFlush, StAcc} state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [DW-1:0]       disc_q, disc_d;
  logic [BITWIDTH-1:0] samp_q, samp_d;
  logic                start_win, acc_en, last;

  logic [CW-1:0] acc_re_q [NUMINPUTS];
  logic [CW-1:0] acc_re_d [NUMINPUTS];
  logic [CW-1:0] acc_im_q [NUMINPUTS];
  logic [CW-1:0] acc_im_d [NUMINPUTS];
  logic [CW-1:0] sum_re   [NUMINPUTS];
  logic [CW-1:0] sum_im   [NUMINPUTS];

  logic [OW-1:0] out_re_q, out_re_d;
  logic [OW-1:0] out_im_q, out_im_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  // Accumulator plus the current sample; also the value loaded on the final sample.
  always_comb begin
    for (int k = 0; k < NUMINPUTS; k++) begin
      sum_re[k] = acc_re_q[k] + CW'(iReal[k]);
      sum_im[k] = acc_im_q[k] + CW'(iImg[k]);
    end
  end

  always_comb begin
    state_d   = state_q;
    disc_d    = disc_q;
    samp_d    = samp_q;
    start_win = 1'b0;
    acc_en    = 1'b0;
    last      = 1'b0;
    case (state_q)
      StIdle: begin
        if (iStart) begin
          start_win = 1'b1;
          disc_d    = '0;
          samp_d    = '0;
          state_d   = (DISCARD > 0) ? StFlush : StAcc;
        end
      end
      StFlush: begin
        if (iEn) begin
          disc_d = disc_q + 1'b1;
          if (disc_q == DiscLast) begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (iEn) begin
          acc_en = 1'b1;
          samp_d = samp_q + 1'b1;
          if (samp_q == SampLast) begin
            last    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (iClr) begin
      state_d   = StIdle;
      disc_d    = '0;
      samp_d    = '0;
      start_win = 1'b0;
      acc_en    = 1'b0;
      last      = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (start_win) begin
      acc_re_d = '{default: '0};
      acc_im_d = '{default: '0};
    end else if (acc_en) begin
      acc_re_d = sum_re;
      acc_im_d = sum_im;
    end
    if (last) begin
      for (int k = 0; k < NUMINPUTS; k++) begin
        out_re_d[k*CW +: CW] = sum_re[k];
        out_im_d[k*CW +: CW] = sum_im[k];
      end
      valid_d = 1'b1;
      // An ack on the completion edge consumes the old result, so no overrun.
      if (valid_q && !iAck) begin
        ovr_d = 1'b1;
      end
    end else if (iAck) begin
      valid_d = 1'b0;
    end
    if (iClr) begin
      acc_re_d = '{default: '0};
      acc_im_d = '{default: '0};
      out_re_d = '0;
      out_im_d = '0;
      valid_d  = 1'b0;
      ovr_d    = 1'b0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      disc_q   <= '0;
      samp_q   <= '0;
      acc_re_q <= '{default: '0};
      acc_im_q <= '{default: '0};
      out_re_q <= '0;
      out_im_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      disc_q   <= disc_d;
      samp_q   <= samp_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign oReal  = out_re_q;
  assign oImg   = out_im_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oOvr   = ovr_q;

endmodule

// File: tb/tb_sfft_bitstream_decoder.sv
// Directed self-checking bench for sfft_bitstream_decoder (L=16, 8 lanes, 3 discarded samples).
module tb_sfft_bitstream_decoder;

  localparam int unsigned BITWIDTH  = 4;
  localparam int unsigned NUMINPUTS = 8;
  localparam int unsigned DISCARD   = 3;
  localparam int unsigned CW        = BITWIDTH + 1;
  localparam int unsigned OW        = NUMINPUTS * CW;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          en;
  logic          start;
  logic [7:0]    re_in;
  logic [7:0]    im_in;
  logic          ack;
  logic [OW-1:0] out_re;
  logic [OW-1:0] out_im;
  logic          valid;
  logic          busy;
  logic          ovr;

  int errors;
  int checks;
  int cyc;
  int first_valid;
  logic prev_valid;

  logic [OW-1:0] exp_tied_re;
  logic [OW-1:0] exp_mix_re;
  logic [OW-1:0] exp_mix_im;

  sfft_bitstream_decoder #(
    .BITWIDTH (BITWIDTH),
    .NUMINPUTS(NUMINPUTS),
    .DISCARD  (DISCARD)
  ) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iClr  (clr),
    .iEn   (en),
    .iStart(start),
    .iReal (re_in),
    .iImg  (im_in),
    .iAck  (ack),
    .oReal (out_re),
    .oImg  (out_im),
    .oValid(valid),
    .oBusy (busy),
    .oOvr  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] r, input logic [7:0] i, input logic e,
                        input logic s, input logic a);
    re_in = r;
    im_in = i;
    en    = e;
    start = s;
    ack   = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid && !prev_valid && first_valid == 0) first_valid = cyc;
    prev_valid = valid;
  endtask

  // mode 0: real all ones, imag all zeros. mode 1: mixed per-lane pattern.
  function automatic logic [7:0] pat_re(input int mode, input int i);
    logic [7:0] r;
    if (mode == 0) return 8'hFF;
    r    = '0;
    r[0] = (i % 2 == 0);
    r[1] = (i < 4);
    r[7] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] pat_im(input int mode, input int i);
    logic [7:0] r;
    if (mode == 0) return 8'h00;
    r    = '0;
    r[0] = (i % 2 == 1);
    r[1] = (i >= 4);
    r[3] = (i == 15);
    return r;
  endfunction

  task automatic run_window(input int mode, input int stall_at, input int stall_len,
                            input bit ack_last, input bit extra_start);
    logic [7:0] jr;
    logic [7:0] ji;
    jr = 8'hFF;
    ji = (mode == 0) ? 8'h00 : 8'hFF;
    cyc = 0;
    first_valid = 0;
    prev_valid = valid;
    set_in(jr, ji, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("busy_after_start", busy, 1);
    for (int j = 0; j < 3; j++) begin
      set_in(jr, ji, 1'b1, extra_start && j == 1, 1'b0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          set_in(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
          tick();
        end
      end
      set_in(pat_re(mode, i), pat_im(mode, i), 1'b1, extra_start && i == 5,
             ack_last && i == 15);
      tick();
    end
    set_in(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic e);
    first_valid = 0;
    prev_valid = valid;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      set_in(8'hFF, 8'hFF, e, 1'b0, 1'b0);
      tick();
    end
    set_in(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ack();
    set_in(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    first_valid = 0;
    prev_valid = 1'b0;
    exp_tied_re = '0;
    exp_mix_re  = '0;
    exp_mix_im  = '0;
    for (int k = 0; k < NUMINPUTS; k++) exp_tied_re[k*CW +: CW] = 5'd16;
    exp_mix_re[0*CW +: CW] = 5'd8;
    exp_mix_re[1*CW +: CW] = 5'd4;
    exp_mix_re[7*CW +: CW] = 5'd16;
    exp_mix_im[0*CW +: CW] = 5'd8;
    exp_mix_im[1*CW +: CW] = 5'd12;
    exp_mix_im[3*CW +: CW] = 5'd1;

    rst = 1'b1;
    clr = 1'b0;
    set_in(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovr", ovr, 0);
    check_eq("rst_real", out_re, 0);
    check_eq("rst_imag", out_im, 0);
    rst = 1'b0;
    tick();

    // All-ones real, all-zeros imag.
    run_window(0, -1, 0, 1'b0, 1'b0);
    check_eq("tied_latency", first_valid, 20);
    check_eq("tied_real", out_re, exp_tied_re);
    check_eq("tied_imag", out_im, 0);
    check_eq("tied_busy_done", busy, 0);
    check_eq("tied_ovr", ovr, 0);
    do_ack();
    check_eq("ack_clears_valid", valid, 0);

    // Mixed pattern with stray starts during FLUSH and ACC.
    run_window(1, -1, 0, 1'b0, 1'b1);
    check_eq("mix_latency", first_valid, 20);
    check_eq("mix_real", out_re, exp_mix_re);
    check_eq("mix_imag", out_im, exp_mix_im);
    do_ack();
    idle(25, 1'b1);
    check_eq("stray_start_one_result", first_valid, 0);
    check_eq("stray_start_idle", busy, 0);

    // Five stalled cycles mid-ACC.
    run_window(1, 6, 5, 1'b0, 1'b0);
    check_eq("stall_latency", first_valid, 25);
    check_eq("stall_real", out_re, exp_mix_re);
    check_eq("stall_imag", out_im, exp_mix_im);
    do_ack();

    // Overrun: two windows without ack.
    run_window(0, -1, 0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check_eq("hold_valid", valid, 1);
    check_eq("hold_real", out_re, exp_tied_re);
    run_window(1, -1, 0, 1'b0, 1'b0);
    check_eq("ovr_valid", valid, 1);
    check_eq("ovr_set", ovr, 1);
    check_eq("ovr_real", out_re, exp_mix_re);
    check_eq("ovr_imag", out_im, exp_mix_im);
    idle(2, 1'b0);
    check_eq("ovr_sticky", ovr, 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_ovr", ovr, 0);
    check_eq("clr_valid", valid, 0);
    check_eq("clr_real", out_re, 0);

    // Ack coincident with the new result: no overrun.
    run_window(0, -1, 0, 1'b0, 1'b0);
    run_window(1, -1, 0, 1'b1, 1'b0);
    check_eq("ackdone_valid", valid, 1);
    check_eq("ackdone_ovr", ovr, 0);
    check_eq("ackdone_real", out_re, exp_mix_re);

    // Clear during FLUSH.
    set_in(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_flush_busy", busy, 0);
    check_eq("clr_flush_valid", valid, 0);
    idle(25, 1'b1);
    check_eq("clr_flush_no_result", first_valid, 0);

    // Async reset mid-ACC with a held result present.
    run_window(0, -1, 0, 1'b0, 1'b0);
    set_in(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 7; k++) begin
      set_in(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_eq("pre_rst_valid", valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", valid, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_real", out_re, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(25, 1'b1);
    check_eq("rst_abort_no_result", first_valid, 0);
    check_eq("rst_abort_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
